// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game datapath: the obstacle scroller state type
// and the playfield constants that the scroller and the shape renderer must
// agree on.
//   scroll_state_t      : IDLE / RUN / PAUSED / DONE
//   WRAP_DEFAULT        : largest legal obstacle position
//   LEVEL_TICKS_DEFAULT : frame ticks in one level
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } scroll_state_t;

    localparam int WRAP_DEFAULT        = 695;
    localparam int LEVEL_TICKS_DEFAULT = 1800;

endpackage

// File: rtl/lane_wrap_counter.sv
// ---------------------------------------------------------------------------
// lane_wrap_counter
// One obstacle lane. The position advances by 'step' whenever 'advance' is
// high and wraps modulo WRAP+1. 'wrap' pulses for one cycle, in the same cycle
// that the wrapped position appears.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   clear         : reload OFFSET (same effect as reset)
//   advance       : move the obstacle by 'step' this cycle
//   step          : distance per advance (never larger than WRAP)
//   pos           : registered lane position, 0..WRAP
//   wrap          : registered one-cycle wrap indication
// ---------------------------------------------------------------------------
module lane_wrap_counter
    import game_pkg::*;
#(
    parameter int               POS_W  = 10,
    parameter int               WRAP   = WRAP_DEFAULT,
    parameter logic [POS_W-1:0] OFFSET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [POS_W-1:0] step,
    output logic [POS_W-1:0] pos,
    output logic             wrap
);

    localparam logic [POS_W:0]   WRAP_V = (POS_W+1)'(WRAP);
    // Modular subtraction in POS_W bits gives the right answer because the
    // wrapped result is always below WRAP+1, even if WRAP+1 is 2^POS_W.
    localparam logic [POS_W-1:0] MOD_V  = POS_W'(WRAP + 1);

    // One extra bit so that pos + step can never overflow before the compare.
    logic [POS_W:0] sum;

    assign sum = {1'b0, pos} + {1'b0, step};

    // Position register. A single subtraction suffices because step <= WRAP
    // keeps the sum below 2*(WRAP+1).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pos  <= OFFSET;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (advance) begin
                if (sum > WRAP_V) begin
                    pos  <= sum[POS_W-1:0] - MOD_V;
                    wrap <= 1'b1;
                end else begin
                    pos  <= sum[POS_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/obstacle_scroller.sv
// ---------------------------------------------------------------------------
// obstacle_scroller
// Advances NUM_LANES obstacle positions by a shared step on every frame tick
// while running. The step ramps by STEP_INIT every RAMP_TICKS ticks up to
// STEP_MAX. Level time is counted and a completion pulse is raised when it
// reaches LEVEL_TICKS. Any of the clear requests returns everything to its
// reset values.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   tick                             : one-cycle frame enable
//   menuScreen, playerWon, playerLost: clear requests (ORed)
//   pause                            : level-sensitive freeze request
//   obj_pos                          : lane i at [i*POS_W +: POS_W]
//   game_time                        : ticks elapsed in the current level
//   step                             : current step
//   wrap_pulse                       : per-lane one-cycle wrap pulse
//   levelDone                        : one-cycle level completion pulse
//   running                          : high while in RUN
// All outputs are registered.
// ---------------------------------------------------------------------------
module obstacle_scroller
    import game_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int POS_W       = 10,
    parameter int WRAP        = WRAP_DEFAULT,
    parameter int TIME_W      = 24,
    parameter int LEVEL_TICKS = LEVEL_TICKS_DEFAULT,
    parameter int STEP_INIT   = 10,
    parameter int STEP_MAX    = 40,
    parameter int RAMP_TICKS  = 300
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       menuScreen,
    input  logic                       playerWon,
    input  logic                       playerLost,
    input  logic                       pause,
    output logic [NUM_LANES*POS_W-1:0] obj_pos,
    output logic [TIME_W-1:0]          game_time,
    output logic [POS_W-1:0]           step,
    output logic [NUM_LANES-1:0]       wrap_pulse,
    output logic                       levelDone,
    output logic                       running
);

    localparam int RAMP_W = $clog2(RAMP_TICKS + 1);

    // Parameter sanity: a step larger than WRAP would need more than one
    // subtraction to wrap, and the level length must fit in game_time.
    generate
        if (STEP_MAX > WRAP) begin : g_bad_step_max
            $error("obstacle_scroller: STEP_MAX must not exceed WRAP");
        end
        if (TIME_W < 31 && LEVEL_TICKS >= (1 << TIME_W)) begin : g_bad_level_ticks
            $error("obstacle_scroller: LEVEL_TICKS does not fit in TIME_W bits");
        end
    endgenerate

    scroll_state_t     state;
    scroll_state_t     next_state;
    logic              clr;
    logic              advance;
    logic [TIME_W-1:0] time_next;
    logic              level_hit;
    logic [RAMP_W-1:0] ramp_cnt;
    logic [RAMP_W-1:0] ramp_next;
    logic              ramp_hit;
    logic [POS_W:0]    step_sum;
    logic [POS_W-1:0]  step_ramped;

    assign clr = menuScreen | playerWon | playerLost;

    // A tick only counts in RUN with no pause and no clear in the same cycle.
    assign advance = (state == RUN) && tick && !pause && !clr;

    assign time_next = game_time + 1'b1;
    assign level_hit = (time_next == TIME_W'(LEVEL_TICKS));
    assign ramp_next = ramp_cnt + 1'b1;
    assign ramp_hit  = (ramp_next == RAMP_W'(RAMP_TICKS));

    // Step ramp saturates at STEP_MAX; the extra bit avoids overflow on the add.
    assign step_sum    = {1'b0, step} + (POS_W+1)'(STEP_INIT);
    assign step_ramped = (step_sum > (POS_W+1)'(STEP_MAX)) ? POS_W'(STEP_MAX)
                                                           : step_sum[POS_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A clear overrides every transition; pause beats tick
    // in RUN; leaving PAUSED swallows any tick in that cycle because advance
    // only looks at the current state.
    always_comb begin
        next_state = state;
        if (clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = RUN;
                RUN: begin
                    if (pause) begin
                        next_state = PAUSED;
                    end else if (tick && level_hit) begin
                        next_state = DONE;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        next_state = RUN;
                    end
                end
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Level time, ramp counter, step and the registered status outputs.
    // 'running' is registered from next_state so it always equals the
    // state register's RUN decode.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            game_time <= '0;
            ramp_cnt  <= '0;
            step      <= POS_W'(STEP_INIT);
            levelDone <= 1'b0;
            running   <= 1'b0;
        end else begin
            levelDone <= 1'b0;
            running   <= (next_state == RUN);
            if (advance) begin
                game_time <= time_next;
                levelDone <= level_hit;
                if (ramp_hit) begin
                    ramp_cnt <= '0;
                    step     <= step_ramped;
                end else begin
                    ramp_cnt <= ramp_next;
                end
            end
        end
    end

    // One wrap counter per lane, each starting at its own evenly spaced offset.
    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            lane_wrap_counter #(
                .POS_W  (POS_W),
                .WRAP   (WRAP),
                .OFFSET (POS_W'(i * ((WRAP + 1) / NUM_LANES)))
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .clear   (clr),
                .advance (advance),
                .step    (step),
                .pos     (obj_pos[i*POS_W +: POS_W]),
                .wrap    (wrap_pulse[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_obstacle_scroller.sv
// ---------------------------------------------------------------------------
// tb_obstacle_scroller
// Self-checking bench for obstacle_scroller at default parameters. Every
// driven cycle runs a behavioural model and pushes the expected registered
// outputs into a scoreboard queue; each scenario task pops and compares after
// the clock edge, and adds fixed-value checks at the scenario's key points.
// ---------------------------------------------------------------------------
module tb_obstacle_scroller;

    typedef struct packed {
        logic [39:0] pos;
        logic [23:0] gt;
        logic [9:0]  stp;
        logic [3:0]  wp;
        logic        ld;
        logic        run;
    } exp_t;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_DONE   = 3;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        menuScreen;
    logic        playerWon;
    logic        playerLost;
    logic        pause;
    logic [39:0] obj_pos;
    logic [23:0] game_time;
    logic [9:0]  step;
    logic [3:0]  wrap_pulse;
    logic        levelDone;
    logic        running;

    exp_t        sb[$];
    exp_t        exp_v;
    logic [79:0] got_v;
    int          checks;
    int          passed;

    int m_state;
    int m_pos[4];
    int m_gt;
    int m_step;
    int m_ramp;

    obstacle_scroller dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .menuScreen (menuScreen),
        .playerWon  (playerWon),
        .playerLost (playerLost),
        .pause      (pause),
        .obj_pos    (obj_pos),
        .game_time  (game_time),
        .step       (step),
        .wrap_pulse (wrap_pulse),
        .levelDone  (levelDone),
        .running    (running)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model reset values: lanes evenly spaced over 0..695.
    task automatic model_reset();
        m_state = S_IDLE;
        for (int i = 0; i < 4; i++) m_pos[i] = i * 174;
        m_gt   = 0;
        m_step = 10;
        m_ramp = 0;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected
    // outputs, then wait until just after the clock edge.
    task automatic applyStimulus(input logic rst, input logic t, input logic p,
                                 input logic ms, input logic pw, input logic pl);
        exp_t       e;
        logic [3:0] wp;
        logic       ld;
        reset = rst; tick = t; pause = p;
        menuScreen = ms; playerWon = pw; playerLost = pl;
        wp = '0;
        ld = 1'b0;
        if (rst || ms || pw || pl) begin
            model_reset();
        end else begin
            case (m_state)
                S_IDLE: m_state = S_RUN;
                S_RUN: begin
                    if (p) begin
                        m_state = S_PAUSED;
                    end else if (t) begin
                        for (int i = 0; i < 4; i++) begin
                            m_pos[i] = m_pos[i] + m_step;
                            if (m_pos[i] > 695) begin
                                m_pos[i] = m_pos[i] - 696;
                                wp[i] = 1'b1;
                            end
                        end
                        m_gt   = m_gt + 1;
                        m_ramp = m_ramp + 1;
                        if (m_ramp == 300) begin
                            m_ramp = 0;
                            m_step = (m_step + 10 > 40) ? 40 : m_step + 10;
                        end
                        if (m_gt == 1800) begin
                            ld = 1'b1;
                            m_state = S_DONE;
                        end
                    end
                end
                S_PAUSED: if (!p) m_state = S_RUN;
                default: ;
            endcase
        end
        e.pos = {10'(m_pos[3]), 10'(m_pos[2]), 10'(m_pos[1]), 10'(m_pos[0])};
        e.gt  = 24'(m_gt);
        e.stp = 10'(m_step);
        e.wp  = wp;
        e.ld  = ld;
        e.run = (m_state == S_RUN);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset for one cycle then let the FSM reach RUN without ticking.
    task automatic start_level();
        applyStimulus(1, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL reset_model got %h expected %h", got_v, exp_v);
            else passed++;
        end
        checks++;
        if ({obj_pos, game_time, step, wrap_pulse, levelDone, running} !==
            {10'd522, 10'd348, 10'd174, 10'd0, 24'd0, 10'd10, 4'd0, 1'b0, 1'b0})
            $display("[TB] FAIL reset_values got pos=%h time=%0d step=%0d wp=%b ld=%b run=%b expected pos=%h time=0 step=10 wp=0 ld=0 run=0",
                     obj_pos, game_time, step, wrap_pulse, levelDone, running,
                     {10'd522, 10'd348, 10'd174, 10'd0});
        else passed++;
    endtask

    task automatic test_first_tick();
        for (int n = 0; n < 2; n++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL idle_to_run got %h expected %h", got_v, exp_v);
            else passed++;
        end
        applyStimulus(0, 1, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
        checks++;
        if (got_v !== exp_v) $display("[TB] FAIL first_tick_model got %h expected %h", got_v, exp_v);
        else passed++;
        checks++;
        if ({obj_pos, game_time, running} !== {10'd532, 10'd358, 10'd184, 10'd10, 24'd1, 1'b1})
            $display("[TB] FAIL first_tick_values got pos=%h time=%0d run=%b expected pos=%h time=1 run=1",
                     obj_pos, game_time, running, {10'd532, 10'd358, 10'd184, 10'd10});
        else passed++;
    endtask

    // Lane 3 starts at 522; the 18th tick takes it from 692 to 702 -> 6.
    task automatic test_wrap();
        for (int n = 2; n <= 19; n++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL wrap_model tick %0d got %h expected %h", n, got_v, exp_v);
            else passed++;
            if (n == 18) begin
                checks++;
                if ({obj_pos[39:30], wrap_pulse} !== {10'd6, 4'b1000})
                    $display("[TB] FAIL wrap_lane3 got pos=%0d wp=%b expected pos=6 wp=1000", obj_pos[39:30], wrap_pulse);
                else passed++;
            end
            if (n == 19) begin
                checks++;
                if ({obj_pos[39:30], wrap_pulse} !== {10'd16, 4'b0000})
                    $display("[TB] FAIL wrap_one_cycle got pos=%0d wp=%b expected pos=16 wp=0000", obj_pos[39:30], wrap_pulse);
                else passed++;
            end
        end
    endtask

    task automatic test_ramp_and_level();
        start_level();
        for (int n = 1; n <= 1805; n++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL level_model tick %0d got %h expected %h", n, got_v, exp_v);
            else passed++;
            if (n == 299 || n == 300 || n == 600 || n == 900 || n == 1200) begin
                checks++;
                if (step !== ((n == 299) ? 10'd10 : (n >= 900) ? 10'd40 : 10'(10 + 10 * (n / 300))))
                    $display("[TB] FAIL ramp_step tick %0d got %0d", n, step);
                else passed++;
            end
            if (n == 1799 || n == 1800 || n == 1801) begin
                checks++;
                if ({levelDone, running} !== ((n == 1800) ? 2'b10 : (n == 1799) ? 2'b01 : 2'b00))
                    $display("[TB] FAIL level_done tick %0d got ld=%b run=%b", n, levelDone, running);
                else passed++;
            end
        end
        checks++;
        if (game_time !== 24'd1800) $display("[TB] FAIL done_hold got time=%0d expected 1800", game_time);
        else passed++;
        applyStimulus(0, 1, 0, 0, 1, 0);
        exp_v = sb.pop_front();
        got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
        checks++;
        if (got_v !== {10'd522, 10'd348, 10'd174, 10'd0, 24'd0, 10'd10, 4'd0, 1'b0, 1'b0} || got_v !== exp_v)
            $display("[TB] FAIL won_clear got %h expected %h", got_v, exp_v);
        else passed++;
    endtask

    task automatic test_pause();
        start_level();
        for (int n = 0; n < 16; n++) begin
            // 0-2 run ticks, 3 pause+tick, 4-13 paused ticks, 14 release+tick, 15 tick
            applyStimulus(0, 1, (n >= 3 && n <= 13), 0, 0, 0);
            exp_v = sb.pop_front();
            got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL pause_model cycle %0d got %h expected %h", n, got_v, exp_v);
            else passed++;
            if (n >= 3) begin
                checks++;
                if ({game_time, obj_pos[9:0], running} !==
                    ((n == 15) ? {24'd4, 10'd40, 1'b1} : {24'd3, 10'd30, 1'(n == 14)}))
                    $display("[TB] FAIL pause_freeze cycle %0d got time=%0d lane0=%0d run=%b", n, game_time, obj_pos[9:0], running);
                else passed++;
            end
        end
    endtask

    task automatic test_clear_race();
        start_level();
        for (int n = 1; n <= 1799; n++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
            checks++;
            if (got_v !== exp_v) $display("[TB] FAIL race_model tick %0d got %h expected %h", n, got_v, exp_v);
            else passed++;
        end
        applyStimulus(0, 1, 0, 0, 0, 1);
        exp_v = sb.pop_front();
        got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
        checks++;
        if (got_v !== {10'd522, 10'd348, 10'd174, 10'd0, 24'd0, 10'd10, 4'd0, 1'b0, 1'b0} || got_v !== exp_v)
            $display("[TB] FAIL lost_beats_tick got %h expected %h", got_v, exp_v);
        else passed++;
        applyStimulus(0, 1, 0, 1, 0, 0);
        exp_v = sb.pop_front();
        got_v = {obj_pos, game_time, step, wrap_pulse, levelDone, running};
        checks++;
        if (got_v !== exp_v) $display("[TB] FAIL menu_hold got %h expected %h", got_v, exp_v);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset = 1'b1; tick = 1'b0; pause = 1'b0;
        menuScreen = 1'b0; playerWon = 1'b0; playerLost = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_first_tick();
        test_wrap();
        test_ramp_and_level();
        test_pause();
        test_clear_race();
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
